// File: rtl/vrf_pkg.sv
//==============================================================================
// Module : vrf_pkg
// Shared widths, writeback entry type and FSM state type for the VRF
// writeback requester.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package vrf_pkg;

  localparam int VLEN   = 256;
  localparam int BEAT_W = 64;
  localparam int REG_AW = 5;
  localparam int BEATS  = VLEN / BEAT_W;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic [REG_AW-1:0] vd;
    logic [VLEN-1:0]   data;
  } vrf_wb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/vrf_wb_fifo.sv
//==============================================================================
// Module : vrf_wb_fifo
// Synchronous DEPTH-entry FIFO of writeback entries; head visible the cycle
// after a push, no bypass.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module vrf_wb_fifo
  import vrf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  vrf_wb_entry_t            i_wdata,
  output vrf_wb_entry_t            o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  vrf_wb_entry_t  r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/vrf_wb_requester.sv
//==============================================================================
// Module : vrf_wb_requester
// VALU writeback agent: buffers results, requests the VRF port and writes each
// vector as BEATS beats, resuming at the held beat after preemption.
// Optional: VRF_WB_STATS_EN adds stall_cnt / vec_cnt statistics ports.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module vrf_wb_requester
  import vrf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_AW-1:0]      in_vd,
  input  logic [VLEN-1:0]        in_data,
  output logic                   valu_req,
  input  logic                   valu_gnt,
  output logic                   vrf_we,
  output logic [REG_AW+BW-1:0]   vrf_waddr,
  output logic [BEAT_W-1:0]      vrf_wdata,
`ifdef VRF_WB_STATS_EN
  output logic [31:0]            stall_cnt,
  output logic [31:0]            vec_cnt,
`endif
  output logic                   wb_busy
);

  localparam int             CW          = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0]  C_LAST_BEAT = BW'(BEATS - 1);

  vrf_wb_entry_t  w_push_entry;
  vrf_wb_entry_t  w_head;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_count_next;
  logic           w_push;
  logic           w_last;
  logic [BW-1:0]  r_beat_cnt;
  logic           r_req;
  wb_state_e      r_state;
  wb_state_e      w_state_next;

  assign w_push_entry = '{vd: in_vd, data: in_data};
  assign w_push       = in_valid && !w_full;
  assign in_ready     = !w_full;

  // A grant is only an ownership token; with nothing buffered it is dropped.
  assign vrf_we       = valu_gnt && !w_empty;
  assign w_last       = vrf_we && (r_beat_cnt == C_LAST_BEAT);
  assign w_count_next = w_count + CW'(w_push) - CW'(w_last);

  vrf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push),
    .i_pop   (w_last),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign vrf_waddr = w_empty ? '0 : {w_head.vd, r_beat_cnt};
  assign vrf_wdata = w_empty ? '0 : w_head.data[int'(r_beat_cnt)*BEAT_W +: BEAT_W];
  assign valu_req  = r_req;
  assign wb_busy   = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_beat_cnt <= '0;
      r_req      <= 1'b0;
      r_state    <= IDLE;
    end else begin
      if (vrf_we) r_beat_cnt <= w_last ? '0 : r_beat_cnt + BW'(1);
      r_req   <= (w_count_next != '0);
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_push) w_state_next = REQ;
      REQ: begin
        if (w_last)      w_state_next = (w_count_next != '0) ? REQ : IDLE;
        else if (vrf_we) w_state_next = XFER;
      end
      XFER: if (w_last) w_state_next = (w_count_next != '0) ? REQ : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

`ifdef VRF_WB_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_vec_cnt;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_stall_cnt <= '0;
      r_vec_cnt   <= '0;
    end else begin
      if (r_req && !valu_gnt && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_last) r_vec_cnt <= r_vec_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign vec_cnt   = r_vec_cnt;
`endif

endmodule

`default_nettype wire
